// File: rtl/sipo_word_assembler.sv
// ============================================================================
// Module  : sipo_word_assembler
// Brief   : Serial-to-parallel word assembler with strobe-qualified bits and a
//           one-cycle load pulse. Optional even-parity check: SIPO_PARITY_CHECK_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_word_assembler #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              async_rst,
    input  logic              start,
    input  logic              ser_en,
    input  logic              ser_in,
    output logic [DATA_W-1:0] data_out,
    output logic              load,
    output logic              busy,
    output logic              abort,
    output logic              parity_err
);

    localparam int              CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    // Without parity the final bit goes straight into data_out, so the shift
    // register only ever needs to hold DATA_W-1 earlier bits.
`ifdef SIPO_PARITY_CHECK_EN
    localparam int SH_W = DATA_W;
`else
    localparam int SH_W = DATA_W - 1;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
`ifdef SIPO_PARITY_CHECK_EN
        PARITY = 2'd3,
`endif
        DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SH_W-1:0]     shreg_q, shreg_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                load_q, load_d;
    logic                busy_q, busy_d;
    logic                abort_q, abort_d;
    logic [DATA_W-1:0]   w_shifted;
    logic [SH_W-1:0]     w_keep;

    generate
        if (MSB_FIRST) begin : g_msb_first
`ifdef SIPO_PARITY_CHECK_EN
            assign w_shifted = {shreg_q[DATA_W-2:0], ser_in};
            assign w_keep    = w_shifted;
`else
            assign w_shifted = {shreg_q, ser_in};
            assign w_keep    = w_shifted[DATA_W-2:0];
`endif
        end else begin : g_lsb_first
`ifdef SIPO_PARITY_CHECK_EN
            assign w_shifted = {ser_in, shreg_q[DATA_W-1:1]};
            assign w_keep    = w_shifted;
`else
            assign w_shifted = {ser_in, shreg_q};
            assign w_keep    = w_shifted[DATA_W-1:1];
`endif
        end
    endgenerate

`ifdef SIPO_PARITY_CHECK_EN
    logic perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        abort_d = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            SHIFT: begin
                if (start) begin
                    cnt_d   = '0;
                    shreg_d = '0;
                    abort_d = 1'b1;
                end else if (ser_en) begin
                    shreg_d = w_keep;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = '0;
`ifdef SIPO_PARITY_CHECK_EN
                        state_d = PARITY;
`else
                        data_d  = w_shifted;
                        state_d = DONE;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef SIPO_PARITY_CHECK_EN
            PARITY: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                    abort_d = 1'b1;
                end else if (ser_en) begin
                    // Even parity: data bits plus parity bit must XOR to zero.
                    if ((^shreg_q) == ser_in) begin
                        data_d  = shreg_q;
                        state_d = DONE;
                    end else begin
                        perr_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        load_d = (state_d == DONE);
`ifdef SIPO_PARITY_CHECK_EN
        busy_d = (state_d == SHIFT) || (state_d == PARITY);
`else
        busy_d = (state_d == SHIFT);
`endif
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            abort_q <= abort_d;
        end
    end

`ifdef SIPO_PARITY_CHECK_EN
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out = data_q;
    assign load     = load_q;
    assign busy     = busy_q;
    assign abort    = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_sipo_word_assembler.sv
// ============================================================================
// Module  : tb_sipo_word_assembler
// Brief   : Directed/randomized bench for sipo_word_assembler, MSB- and
//           LSB-first instances driven in parallel.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sipo_word_assembler;

    logic       clk = 1'b0;
    logic       async_rst;
    logic       start, ser_en, ser_in;
    logic [7:0] d_m, d_l;
    logic       ld_m, ld_l, bz_m, bz_l, ab_m, ab_l, pe_m, pe_l;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_m, exp_l;

    always #5 clk = ~clk;

    sipo_word_assembler #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .async_rst(async_rst), .start(start), .ser_en(ser_en),
        .ser_in(ser_in), .data_out(d_m), .load(ld_m), .busy(bz_m),
        .abort(ab_m), .parity_err(pe_m)
    );

    sipo_word_assembler #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .async_rst(async_rst), .start(start), .ser_en(ser_en),
        .ser_in(ser_in), .data_out(d_l), .load(ld_l), .busy(bz_l),
        .abort(ab_l), .parity_err(pe_l)
    );

    // Reference placement: bits[7] is the first bit on the wire.
    function automatic logic [7:0] place(input logic [7:0] bits, input bit msb_first);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (msb_first) r[7-i] = bits[7-i];
            else           r[i]   = bits[7-i];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pulses(input string tag, input logic ld, input logic ab);
        chk({tag, ".load_m"}, {31'd0, ld_m}, {31'd0, ld});
        chk({tag, ".load_l"}, {31'd0, ld_l}, {31'd0, ld});
        chk({tag, ".abort_m"}, {31'd0, ab_m}, {31'd0, ab});
        chk({tag, ".abort_l"}, {31'd0, ab_l}, {31'd0, ab});
    endtask

    task automatic chk_data(input string tag);
        chk({tag, ".data_m"}, {24'd0, d_m}, {24'd0, exp_m});
        chk({tag, ".data_l"}, {24'd0, d_l}, {24'd0, exp_l});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            start  = 1'b0;
            ser_en = 1'($urandom);
            ser_in = 1'($urandom);
            tick();
            chk_pulses("idle", 1'b0, 1'b0);
            chk("idle.busy", {31'd0, bz_m | bz_l}, 32'd0);
            chk("idle.perr", {31'd0, pe_m | pe_l}, 32'd0);
            chk_data("idle");
        end
        ser_en = 1'b0;
    endtask

    task automatic do_start(input bit expect_abort, input bit force_en);
        start  = 1'b1;
        ser_en = force_en ? 1'b1 : 1'($urandom);
        ser_in = 1'($urandom);
        tick();
        start  = 1'b0;
        ser_en = 1'b0;
        chk("start.busy", {30'd0, bz_m, bz_l}, 32'd3);
        chk_pulses("start", 1'b0, expect_abort);
        chk_data("start");
    endtask

    task automatic shift_bits(input logic [7:0] bits, input int gap_max,
                              input int nbits, input bit bad_parity);
        for (int i = 0; i < nbits; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                ser_en = 1'b0;
                ser_in = 1'($urandom);
                tick();
                chk_pulses("gap", 1'b0, 1'b0);
            end
            ser_en = 1'b1;
            ser_in = bits[7-i];
            tick();
            ser_en = 1'b0;
            if (i < 7) begin
                chk_pulses("bit", 1'b0, 1'b0);
                chk("bit.busy", {30'd0, bz_m, bz_l}, 32'd3);
                chk_data("bit");
            end
        end
        if (nbits == 8) begin
`ifdef SIPO_PARITY_CHECK_EN
            chk_pulses("par_wait", 1'b0, 1'b0);
            chk("par_wait.busy", {30'd0, bz_m, bz_l}, 32'd3);
            chk_data("par_wait");
            ser_en = 1'b1;
            ser_in = (^bits) ^ bad_parity;
            tick();
            ser_en = 1'b0;
            if (bad_parity) begin
                chk("par.perr", {30'd0, pe_m, pe_l}, 32'd3);
                chk_pulses("par_bad", 1'b0, 1'b0);
                chk_data("par_bad");
                return;
            end
            chk("par.perr0", {30'd0, pe_m, pe_l}, 32'd0);
`else
            chk("word.perr", {31'd0, bad_parity & (pe_m | pe_l)}, 32'd0);
`endif
            exp_m = place(bits, 1'b1);
            exp_l = place(bits, 1'b0);
            chk_pulses("word", 1'b1, 1'b0);
            chk("word.busy", {30'd0, bz_m, bz_l}, 32'd0);
            chk_data("word");
        end
    endtask

    initial begin
        logic [7:0] w;
        async_rst = 1'b1;
        start = 1'b0; ser_en = 1'b0; ser_in = 1'b0;
        exp_m = 8'h00; exp_l = 8'h00;
        #3;
        chk_pulses("reset", 1'b0, 1'b0);
        chk("reset.busy", {30'd0, bz_m, bz_l}, 32'd0);
        chk("reset.perr", {30'd0, pe_m, pe_l}, 32'd0);
        chk_data("reset");
        @(negedge clk);
        async_rst = 1'b0;
        tick();
        idle(3);

        // 1,0,1,0,0,1,0,1 -> A5 for both orders (palindrome)
        do_start(1'b0, 1'b0);
        shift_bits(8'hA5, 0, 8, 1'b0);
        idle(2);

        // 1 then seven 0s: LSB-first yields 01, MSB-first yields 80
        do_start(1'b0, 1'b0);
        shift_bits(8'h80, 0, 8, 1'b0);
        idle(1);

        // gapped strobes, back-to-back frames (start in the DONE cycle)
        do_start(1'b0, 1'b0);
        shift_bits(8'h3C, 3, 8, 1'b0);
        do_start(1'b0, 1'b0);
        shift_bits(8'hFF, 3, 8, 1'b0);
        idle(2);

        // abort mid-word with a simultaneous strobe
        do_start(1'b0, 1'b0);
        shift_bits(8'hC3, 2, 4, 1'b0);
        do_start(1'b1, 1'b1);
        shift_bits(8'h5A, 2, 8, 1'b0);
        idle(1);

        // random words, some back-to-back
        for (int f = 0; f < 6; f++) begin
            w = 8'($urandom);
            do_start(1'b0, 1'b0);
            shift_bits(w, 3, 8, 1'b0);
            if ($urandom_range(0, 1) == 0) idle(1);
        end
        idle(1);

        // async reset between edges in the middle of a frame
        do_start(1'b0, 1'b0);
        shift_bits(8'($urandom), 1, 5, 1'b0);
        #3;
        async_rst = 1'b1;
        #1;
        exp_m = 8'h00; exp_l = 8'h00;
        chk_pulses("midrst", 1'b0, 1'b0);
        chk("midrst.busy", {30'd0, bz_m, bz_l}, 32'd0);
        chk_data("midrst");
        @(posedge clk);
        @(negedge clk);
        async_rst = 1'b0;
        tick();
        idle(3);
        do_start(1'b0, 1'b0);
        shift_bits(8'h96, 1, 8, 1'b0);
        idle(1);

`ifdef SIPO_PARITY_CHECK_EN
        do_start(1'b0, 1'b0);
        shift_bits(8'hA5, 1, 8, 1'b0);
        idle(1);
        do_start(1'b0, 1'b0);
        shift_bits(8'hA5, 1, 8, 1'b1);
        idle(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sipo_word_assembler.md
Name: sipo_word_assembler

Overview:
- Serial-in/parallel-out front end feeding the 8-bit load-enable holding register.
- Assembles DATA_W serial bits, qualified by a bit strobe, into one parallel word.
- Presents the word on data_out with a one-cycle load pulse; the pair wires directly to the register's data_in/load.
- Tracks frame progress with a bit counter and a small FSM.

Parameters:
- DATA_W, 8, word width in bits (>=2).
- MSB_FIRST, 1, 1 = first received bit lands in data_out[DATA_W-1]; 0 = first bit lands in data_out[0].

Ports:
- clk  input  1  system clock, rising edge.
- async_rst  input  1  asynchronous reset, active high.
- start  input  1  frame start; sampled on clk.
- ser_en  input  1  bit strobe; ser_in is valid when high.
- ser_in  input  1  serial data bit.
- data_out  output  DATA_W  last completed word.
- load  output  1  one-cycle pulse; data_out holds a new word.
- busy  output  1  high in SHIFT (and PARITY when enabled).
- abort  output  1  one-cycle pulse; frame restarted mid-word.
- parity_err  output  1  one-cycle pulse on parity mismatch (optional feature only).

Behaviour:
- Async reset: state=IDLE, bit count=0, shift reg=0, data_out=0, load=0, busy=0, abort=0, parity_err=0. Reset mid-frame discards the partial word.
- All outputs are registered. load, abort and parity_err are single-cycle pulses.
- FSM states: IDLE, SHIFT, DONE, plus PARITY when the optional feature is enabled.
- IDLE:
  - start=1 -> SHIFT; count=0; shift reg cleared.
  - ser_en in IDLE is ignored, including in the start cycle.
- SHIFT:
  - On each ser_en=1, shift ser_in in and increment the count.
  - MSB_FIRST=1: shift left, new bit in at LSB. MSB_FIRST=0: shift right, new bit in at MSB.
  - When ser_en=1 and count==DATA_W-1: data_out <= completed word (including this bit); count wraps to 0; next state DONE.
- DONE:
  - load=1 for exactly this one cycle; data_out is valid in the same cycle.
  - Next state IDLE, or SHIFT if start=1 in this cycle (back-to-back frames).
  - ser_en in DONE is ignored.
- start during SHIFT (simultaneous ser_en included):
  - Restart: count=0, shift reg cleared, the ser_en bit is dropped.
  - abort=1 next cycle; state stays SHIFT; no load; data_out unchanged.
- Latency: load and the new data_out appear 1 clk after the edge that samples the final bit.
- data_out changes only on the transition into DONE. It holds between words and is never cleared except by reset.
- Count width: clog2(DATA_W). The count never exceeds DATA_W-1.
- ser_en gaps of any length are allowed in SHIFT; there is no timeout.

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- Defined:
  - After the last data bit, go to PARITY instead of DONE; data_out is not yet updated.
  - The next ser_en bit is the even-parity bit.
  - Match (XOR of data bits and parity bit = 0): data_out <= word, then DONE, load pulse.
  - Mismatch: parity_err=1 for one cycle, no load, data_out unchanged, return to IDLE.
  - start during PARITY restarts as in SHIFT (abort pulse).
- Undefined: no PARITY state; parity_err is tied to 0.

Test Plan:
- Reset: assert async_rst mid-clock between edges -> all outputs 0 immediately; FSM in IDLE on release.
- MSB_FIRST=1: start, then bits 1,0,1,0,0,1,0,1 on consecutive ser_en -> data_out=8'hA5, load high exactly 1 cycle, 1 clk after the 8th bit.
- MSB_FIRST=0: same bit sequence -> data_out=8'hA5 reversed = 8'hA5 (palindrome check); then bits of 8'h01 LSB-first -> data_out=8'h01.
- Gapped strobes plus back-to-back frames: ser_en with random idle gaps, start asserted in the DONE cycle, words 8'h3C then 8'hFF -> two load pulses, data_out=8'h3C then 8'hFF, no bits lost.
- Abort: start, 4 bits, start again with ser_en=1 -> abort pulse, no load; next 8 bits give 8'h5A -> data_out=8'h5A; the previous data_out holds until then.
- SIPO_PARITY_CHECK_EN: 8'hA5 with parity 0 -> load and data_out=8'hA5; 8'hA5 with parity 1 -> parity_err pulse, no load, data_out stays 8'hA5 from before.
